// File: rtl/prm_edge_mask_engine.sv
// Programmable sum-of-products edge-mask engine: scans a run-time loaded cube memory
// one entry per cycle and ORs matching cubes into a per-edge mask. Optional macro: PRM_EARLY_EXIT_EN.
module prm_edge_mask_engine #(
  parameter int IN_W     = 15,
  parameter int NUM_EDGE = 8,
  parameter int CUBES    = 64,
  parameter int EW       = (NUM_EDGE > 1) ? $clog2(NUM_EDGE) : 1,
  parameter int AW       = $clog2(CUBES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [IN_W-1:0]     cfg_care,
  input  logic [IN_W-1:0]     cfg_val,
  input  logic [EW-1:0]       cfg_edge,
  input  logic                cfg_clr,
  output logic                cfg_err,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [IN_W-1:0]     q_vec,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [NUM_EDGE-1:0] r_mask,
  output logic [AW:0]         r_hits,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [AW:0]   HITS_MAX  = (AW+1)'(CUBES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CUBES - 1);

  state_t               state;
  logic [CUBES-1:0]     valid_q;
  logic [CUBES-1:0]     valid_nxt;
  logic [IN_W-1:0]      care_mem [CUBES];
  logic [IN_W-1:0]      val_mem  [CUBES];
  logic [EW-1:0]        edge_mem [CUBES];

  logic [AW-1:0]        addr_p0;
  logic [IN_W-1:0]      qv_p0;
  logic                 hit_p0;
  logic [NUM_EDGE-1:0]  mask_nxt_p0;
  logic                 scan_end_p0;
  logic [NUM_EDGE-1:0]  mask_p1;
  logic [AW:0]          hits_p1;

  logic                 q_ready_r;
  logic                 r_valid_r;
  logic                 busy_r;
  logic                 cfg_err_r;
  logic                 idle;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    if (v >= HITS_MAX) return HITS_MAX;
    return v + 1'b1;
  endfunction

  // Cube edge indices beyond NUM_EDGE-1 simply contribute nothing.
  function automatic logic [NUM_EDGE-1:0] edge_onehot(input logic [EW-1:0] e);
    logic [NUM_EDGE-1:0] oh;
    for (int i = 0; i < NUM_EDGE; i++) oh[i] = (e == EW'(i));
    return oh;
  endfunction

  assign idle = (state == IDLE);

  // Clear takes effect before the write so a combined request leaves exactly one entry.
  always_comb begin
    valid_nxt = valid_q;
    if (idle) begin
      if (cfg_clr) valid_nxt = '0;
      if (cfg_we)  valid_nxt[cfg_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (cfg_we && idle) begin
      care_mem[cfg_addr] <= cfg_care;
      val_mem[cfg_addr]  <= cfg_val;
      edge_mem[cfg_addr] <= cfg_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (idle && q_valid) qv_p0 <= q_vec;
  end

  // Stage p0: combinational read and match of the entry under the scan pointer.
  assign hit_p0 = valid_q[addr_p0] &&
                  (((qv_p0 ^ val_mem[addr_p0]) & care_mem[addr_p0]) == '0);
  assign mask_nxt_p0 = mask_p1 | (hit_p0 ? edge_onehot(edge_mem[addr_p0]) : '0);

`ifdef PRM_EARLY_EXIT_EN
  assign scan_end_p0 = (addr_p0 == LAST_ADDR) || (&mask_nxt_p0);
`else
  assign scan_end_p0 = (addr_p0 == LAST_ADDR);
`endif

  // Stage p1: accumulators and the control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_p0   <= '0;
      mask_p1   <= '0;
      hits_p1   <= '0;
      q_ready_r <= 1'b1;
      r_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= (cfg_we || cfg_clr) && !idle;
      case (state)
        IDLE: begin
          if (q_valid) begin
            state     <= SCAN;
            addr_p0   <= '0;
            mask_p1   <= '0;
            hits_p1   <= '0;
            q_ready_r <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        SCAN: begin
          mask_p1 <= mask_nxt_p0;
          if (hit_p0) hits_p1 <= sat_inc(hits_p1);
          if (scan_end_p0) begin
            state     <= DONE;
            r_valid_r <= 1'b1;
          end else begin
            addr_p0 <= addr_p0 + 1'b1;
          end
        end
        DONE: begin
          if (r_ready) begin
            state     <= IDLE;
            r_valid_r <= 1'b0;
            q_ready_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          q_ready_r <= 1'b1;
          r_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign q_ready = q_ready_r;
  assign r_valid = r_valid_r;
  assign busy    = busy_r;
  assign cfg_err = cfg_err_r;
  assign r_mask  = mask_p1;
  assign r_hits  = hits_p1;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Self-checking bench for prm_edge_mask_engine: directed scenarios plus random cube
// loads and queries compared against a loop-over-entries reference model.
module tb_prm_edge_mask_engine;

  localparam int IN_W     = 15;
  localparam int NUM_EDGE = 8;
  localparam int CUBES    = 64;
  localparam int EW       = 3;
  localparam int AW       = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we = 1'b0;
  logic [AW-1:0]       cfg_addr = '0;
  logic [IN_W-1:0]     cfg_care = '0;
  logic [IN_W-1:0]     cfg_val = '0;
  logic [EW-1:0]       cfg_edge = '0;
  logic                cfg_clr = 1'b0;
  logic                cfg_err;
  logic                q_valid = 1'b0;
  logic                q_ready;
  logic [IN_W-1:0]     q_vec = '0;
  logic                r_valid;
  logic                r_ready = 1'b0;
  logic [NUM_EDGE-1:0] r_mask;
  logic [AW:0]         r_hits;
  logic                busy;

  prm_edge_mask_engine #(.IN_W(IN_W), .NUM_EDGE(NUM_EDGE), .CUBES(CUBES)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_edge(cfg_edge), .cfg_clr(cfg_clr), .cfg_err(cfg_err),
    .q_valid(q_valid), .q_ready(q_ready), .q_vec(q_vec), .r_valid(r_valid),
    .r_ready(r_ready), .r_mask(r_mask), .r_hits(r_hits), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the cube table as the sink would see it.
  logic [IN_W-1:0] m_care [CUBES];
  logic [IN_W-1:0] m_val  [CUBES];
  int              m_edge [CUBES];
  bit              m_valid[CUBES];

  int n_tests = 0;
  int n_fail  = 0;
  int t0;
  int exp_mask, exp_hits, exp_lat;
  int got_mask, got_hits;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < CUBES; i++) m_valid[i] = 0;
  endtask

  task automatic cfg_write(input int a, input int c, input int v, input int e);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_care = IN_W'(c); cfg_val = IN_W'(v); cfg_edge = EW'(e);
    step();
    cfg_we = 1'b0;
    m_care[a] = IN_W'(c); m_val[a] = IN_W'(v); m_edge[a] = e; m_valid[a] = 1;
  endtask

  task automatic cfg_clear();
    cfg_clr = 1'b1;
    step();
    cfg_clr = 1'b0;
    model_clear();
  endtask

  task automatic model_eval(input logic [IN_W-1:0] v);
    exp_mask = 0; exp_hits = 0; exp_lat = CUBES;
    for (int i = 0; i < CUBES; i++) begin
      if (m_valid[i] && (((v ^ m_val[i]) & m_care[i]) == 0)) begin
        exp_mask |= (1 << m_edge[i]);
        exp_hits++;
      end
`ifdef PRM_EARLY_EXIT_EN
      if (exp_mask == (1 << NUM_EDGE) - 1) begin
        exp_lat = i + 1;
        break;
      end
`endif
    end
  endtask

  task automatic start_q(input string tag, input logic [IN_W-1:0] v);
    model_eval(v);
    check({tag, "_qready"}, q_ready, 1);
    q_valid = 1'b1; q_vec = v;
    step();
    t0 = cyc;
    q_valid = 1'b0; q_vec = IN_W'($urandom);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic finish_q(input string tag, input int hold);
    while (!r_valid && (cyc - t0) < CUBES + 10) step();
    check({tag, "_rvalid"}, r_valid, 1);
    check({tag, "_latency"}, cyc - t0, exp_lat);
    check({tag, "_mask"}, r_mask, exp_mask);
    check({tag, "_hits"}, r_hits, exp_hits);
    got_mask = int'(r_mask); got_hits = int'(r_hits);
    if (hold > 0) begin
      q_valid = 1'b1; q_vec = IN_W'($urandom);
      for (int k = 0; k < hold; k++) begin
        step();
        check({tag, "_hold_rvalid"}, r_valid, 1);
        check({tag, "_hold_mask"}, r_mask, got_mask);
        check({tag, "_hold_hits"}, r_hits, got_hits);
        check({tag, "_hold_qready"}, q_ready, 0);
      end
      q_valid = 1'b0;
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check({tag, "_rvalid_drop"}, r_valid, 0);
    check({tag, "_qready_back"}, q_ready, 1);
  endtask

  task automatic run_q(input string tag, input logic [IN_W-1:0] v);
    start_q(tag, v);
    finish_q(tag, 0);
  endtask

  initial begin
    int k;
    logic [IN_W-1:0] qv;
    model_clear();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_qready", q_ready, 1);
    check("rst_rvalid", r_valid, 0);
    check("rst_mask", r_mask, 0);
    check("rst_hits", r_hits, 0);
    check("rst_busy", busy, 0);
    check("rst_cfgerr", cfg_err, 0);

    // Single literal cube on edge 2.
    cfg_write(0, 'h739A, 'h3188, 2);
    run_q("q3188", 15'h3188);
    check("q3188_const_mask", got_mask, 'h04);
    check("q3188_const_hits", got_hits, 1);
    run_q("q3189", 15'h3189);
    check("q3189_const_mask", got_mask, 'h04);
    run_q("q318A", 15'h318A);
    check("q318A_const_mask", got_mask, 'h00);
    check("q318A_const_hits", got_hits, 0);

    // Constant-true cubes covering every edge.
    cfg_clear();
    for (int i = 0; i < 8; i++) cfg_write(i, 0, $urandom, i);
    run_q("all_true", IN_W'($urandom));
    check("all_true_const_mask", got_mask, 'hFF);
    check("all_true_const_hits", got_hits, 8);

    // Configuration write while scanning is dropped and flagged.
    cfg_clear();
    cfg_write(0, 0, 0, 0);
    start_q("busy_we", IN_W'($urandom));
    repeat (3) step();
    cfg_we = 1'b1; cfg_addr = 5; cfg_care = 0; cfg_val = 0; cfg_edge = 7;
    step();
    cfg_we = 1'b0;
    check("busy_we_err_hi", cfg_err, 1);
    step();
    check("busy_we_err_lo", cfg_err, 0);
    finish_q("busy_we", 0);
    run_q("busy_we_after", IN_W'($urandom));
    check("busy_we_after_const", got_mask, 'h01);

    // Stall the sink in DONE, then clear and re-query.
    cfg_write(9, 'h00F0, 'h0050, 4);
    start_q("stall", 15'h7F5F);
    finish_q("stall", 10);
    cfg_clear();
    run_q("post_clr", IN_W'($urandom));
    check("post_clr_const", got_mask, 0);

    // Combined clear and write leaves exactly the written entry.
    cfg_write(1, 0, 0, 3);
    cfg_write(2, 0, 0, 6);
    cfg_clr = 1'b1;
    cfg_write(7, 0, 0, 5);
    cfg_clr = 1'b0;
    model_clear();
    m_valid[7] = 1;
    run_q("clr_we", IN_W'($urandom));
    check("clr_we_const", got_mask, 'h20);

    // Reset in the middle of a scan.
    cfg_write(0, 0, 0, 1);
    start_q("mid_rst", IN_W'($urandom));
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("mid_rst_qready", q_ready, 1);
    check("mid_rst_rvalid", r_valid, 0);
    check("mid_rst_mask", r_mask, 0);
    check("mid_rst_hits", r_hits, 0);
    check("mid_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    model_clear();
    step();
    run_q("post_rst", IN_W'($urandom));
    check("post_rst_const", got_mask, 0);

    // Randomized tables and queries.
    for (int r = 0; r < 4; r++) begin
      cfg_clear();
      for (int j = 0; j < 12; j++)
        cfg_write($urandom_range(0, CUBES - 1), $urandom & $urandom & 'h7FFF,
                  $urandom & 'h7FFF, $urandom_range(0, NUM_EDGE - 1));
      for (int j = 0; j < 6; j++) begin
        k = $urandom_range(0, CUBES - 1);
        if (m_valid[k] && $urandom_range(0, 1) == 1)
          qv = (m_val[k] & m_care[k]) | (IN_W'($urandom) & ~m_care[k]);
        else
          qv = IN_W'($urandom);
        run_q("rand", qv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
